// File: rtl/conv_window_feeder_if.sv
// Pixel/weight stream bundle between a stream source and conv_window_feeder.
// The master drives the pixel and weight streams; the slave returns the PE operand set.
interface conv_window_feeder_if #(
  parameter int pic_bits    = 2,
  parameter int weight_bits = 3,
  parameter int kernel_size = 5
);
  logic                                                pix_valid;
  logic [pic_bits-1:0]                                 pix_in;
  logic                                                w_load_valid;
  logic [weight_bits-1:0]                              w_in;
  logic [kernel_size*kernel_size-1:0][pic_bits-1:0]    pic;
  logic [kernel_size*kernel_size-1:0][weight_bits-1:0] weight;
  logic                                                in_valid;
  logic                                                weight_ready;
  logic                                                frame_done;

  modport master (
    output pix_valid, pix_in, w_load_valid, w_in,
    input  pic, weight, in_valid, weight_ready, frame_done
  );

  modport slave (
    input  pix_valid, pix_in, w_load_valid, w_in,
    output pic, weight, in_valid, weight_ready, frame_done
  );
endinterface

// File: rtl/conv_window_feeder.sv
// Raster-scan sliding KxK window generator with a serially loaded kernel store.
// Emits one window per accepted pixel once a complete window exists and weights are loaded.
module conv_window_feeder #(
  parameter int pic_bits    = 2,
  parameter int weight_bits = 3,
  parameter int kernel_size = 5,
  parameter int img_width   = 28,
  parameter int img_height  = 28
) (
  input logic              clk,
  input logic              rst_n,
  conv_window_feeder_if.slave bus
);
  localparam int KK    = kernel_size * kernel_size;
  localparam int COL_W = (img_width  > 1) ? $clog2(img_width)  : 1;
  localparam int ROW_W = (img_height > 1) ? $clog2(img_height) : 1;
  localparam int IDX_W = (KK > 1) ? $clog2(KK) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(img_width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(img_height - 1);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(kernel_size - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(kernel_size - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KK - 1);

  typedef enum logic {W_LOAD, W_READY} w_state_t;

  w_state_t                             w_state_reg, w_state_next;
  logic [IDX_W-1:0]                     w_idx_reg, w_idx_next;
  logic [COL_W-1:0]                     col_reg;
  logic [ROW_W-1:0]                     row_reg;
  logic                                 in_valid_reg;
  logic                                 frame_done_reg;
  logic [KK-1:0][pic_bits-1:0]          pic_reg, pic_next;
  logic [KK-1:0][weight_bits-1:0]       weight_reg;
  logic [kernel_size-1:0][pic_bits-1:0] new_col;
  logic                                 win_complete;
  logic                                 frame_last;

  assign win_complete = (row_reg >= ROW_FULL) && (col_reg >= COL_FULL);
  assign frame_last   = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

  // Line buffer gi holds the row that is (K-1-gi) rows above the current one;
  // each accepted pixel pushes the column one buffer up the stack.
  genvar gi;
  generate
    for (gi = 0; gi < kernel_size - 1; gi++) begin : g_lb
      logic [pic_bits-1:0] mem [img_width];
      always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
          mem[col_reg] <= new_col[gi+1];
        end
      end
      assign new_col[gi] = mem[col_reg];
    end
  endgenerate
  assign new_col[kernel_size-1] = bus.pix_in;

  generate
    for (gi = 0; gi < KK; gi++) begin : g_win
      if ((gi % kernel_size) == kernel_size - 1) begin : g_edge
        assign pic_next[gi] = new_col[gi / kernel_size];
      end else begin : g_shift
        assign pic_next[gi] = pic_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pic_reg        <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      in_valid_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      in_valid_reg   <= bus.pix_valid && win_complete && (w_state_reg == W_READY);
      frame_done_reg <= bus.pix_valid && frame_last;
      if (bus.pix_valid) begin
        pic_reg <= pic_next;
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
    end
  end

  // A write while ready lands at index 0 (w_idx_reg is 0 then) and starts a reload.
  always_comb begin
    w_state_next = w_state_reg;
    w_idx_next   = w_idx_reg;
    if (bus.w_load_valid) begin
      case (w_state_reg)
        W_LOAD: begin
          if (w_idx_reg == IDX_LAST) begin
            w_state_next = W_READY;
            w_idx_next   = '0;
          end else begin
            w_idx_next   = w_idx_reg + IDX_W'(1);
          end
        end
        W_READY: begin
          w_state_next = W_LOAD;
          w_idx_next   = IDX_W'(1);
        end
        default: begin
          w_state_next = W_LOAD;
          w_idx_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_LOAD;
      w_idx_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      w_idx_reg   <= w_idx_next;
    end
  end

  generate
    for (gi = 0; gi < KK; gi++) begin : g_w
      logic [weight_bits-1:0] w_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_q <= '0;
        end else if (bus.w_load_valid && (w_idx_reg == IDX_W'(gi))) begin
          w_q <= bus.w_in;
        end
      end
      assign weight_reg[gi] = w_q;
    end
  endgenerate

  assign bus.pic          = pic_reg;
  assign bus.weight       = weight_reg;
  assign bus.in_valid     = in_valid_reg;
  assign bus.frame_done   = frame_done_reg;
  assign bus.weight_ready = (w_state_reg == W_READY);
endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomized bench for conv_window_feeder against a frame-image reference model.
// Windows are recomputed from the stored image of the current frame.
module tb_conv_window_feeder;
  localparam int PB = 2, WB = 3, K = 5, W = 8, H = 6, KK = K * K;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_window_feeder_if #(.pic_bits(PB), .weight_bits(WB), .kernel_size(K)) bus ();

  conv_window_feeder #(
    .pic_bits(PB), .weight_bits(WB), .kernel_size(K), .img_width(W), .img_height(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [PB-1:0]          img [H][W];
  int                     mr, mc;
  logic [KK-1:0][PB-1:0]  pic_exp;
  bit                     pic_known;
  logic [KK-1:0][WB-1:0]  w_exp;
  bit                     m_ready;
  int                     m_idx;
  int                     acc_cnt, win_cnt, fd_cnt, first_at, exp_win;
  logic [KK-1:0][PB-1:0]  first_pic;

  task automatic model_reset();
    mr = 0; mc = 0;
    pic_exp = '0; pic_known = 1;
    w_exp = '0; m_ready = 0; m_idx = 0;
    acc_cnt = 0;
  endtask

  task automatic step(input logic pv, input logic [PB-1:0] px,
                      input logic wv, input logic [WB-1:0] wi);
    logic exp_iv, exp_fd;
    @(negedge clk);
    bus.pix_valid = pv; bus.pix_in = px; bus.w_load_valid = wv; bus.w_in = wi;
    exp_iv = 1'b0; exp_fd = 1'b0;
    if (pv) begin
      if (mr == 0 && mc == 0) acc_cnt = 0;
      acc_cnt++;
      img[mr][mc] = px;
      if (mr >= K - 1 && mc >= K - 1) begin
        for (int i = 0; i < KK; i++) pic_exp[i] = img[mr - K + 1 + i / K][mc - K + 1 + i % K];
        pic_known = 1;
        exp_iv = m_ready;
      end else begin
        pic_known = 0;
      end
      exp_fd = (mr == H - 1 && mc == W - 1);
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    if (wv) begin
      if (m_ready) begin m_ready = 0; m_idx = 0; end
      w_exp[m_idx] = wi;
      if (m_idx == KK - 1) begin m_ready = 1; m_idx = 0; end
      else m_idx++;
    end
    if (exp_iv) exp_win++;
    @(posedge clk);
    #1;
    check_val("in_valid", bus.in_valid, exp_iv);
    check_val("frame_done", bus.frame_done, exp_fd);
    check_val("weight_ready", bus.weight_ready, m_ready);
    check_val("weight", bus.weight, w_exp);
    if (pic_known) check_val("pic", bus.pic, pic_exp);
    if (bus.in_valid) begin
      win_cnt++;
      if (first_at == 0) begin first_at = acc_cnt; first_pic = bus.pic; end
      $display("window %0d after pixel %0d pic=%h weight=%h", win_cnt, acc_cnt, bus.pic, bus.weight);
    end
    if (bus.frame_done) fd_cnt++;
  endtask

  task automatic load_weights(input bit use_mod8);
    for (int i = 0; i < KK; i++) begin
      step(1'b0, '0, 1'b1, use_mod8 ? WB'(i % 8) : WB'($urandom));
    end
  endtask

  // mode 0: col%4 continuous, 1: col%4 gapped 1,0, 2: random pixels with random gaps
  task automatic stream_frame(input int mode, input bit reload);
    int n, cyc, left;
    logic pv, wv;
    logic [PB-1:0] px;
    n = 0; cyc = 0; left = reload ? KK : 0;
    win_cnt = 0; fd_cnt = 0; first_at = 0; exp_win = 0;
    while (n < W * H) begin
      case (mode)
        0:       pv = 1'b1;
        1:       pv = (cyc % 2 == 0);
        default: pv = ($urandom_range(0, 3) != 0);
      endcase
      px = (mode == 2) ? PB'($urandom) : PB'((n % W) % 4);
      wv = (left > 0) && (n >= 10) && ($urandom_range(0, 1) == 1);
      step(pv, px, wv, WB'($urandom));
      if (pv) n++;
      if (wv) left--;
      cyc++;
    end
    while (left > 0) begin
      step(1'b0, '0, 1'b1, WB'($urandom));
      left--;
    end
    check_val("win_count_model", win_cnt, exp_win);
    check_val("frame_done_count", fd_cnt, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_in_valid"}, bus.in_valid, 1'b0);
    check_val({tag, "_frame_done"}, bus.frame_done, 1'b0);
    check_val({tag, "_weight_ready"}, bus.weight_ready, 1'b0);
    check_val({tag, "_pic"}, bus.pic, '0);
    check_val({tag, "_weight"}, bus.weight, '0);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.pix_valid = 1'b0; bus.pix_in = '0; bus.w_load_valid = 1'b0; bus.w_in = '0;
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // no weights: windows are dropped, frame_done still fires
    stream_frame(0, 1'b0);
    check_val("gated_windows", win_cnt, 0);

    load_weights(1'b1);
    check_val("ready_after_load", bus.weight_ready, 1'b1);
    check_val("weight9", bus.weight[9], 1);

    // two back-to-back frames of col%4
    for (int f = 0; f < 2; f++) begin
      stream_frame(0, 1'b0);
      check_val("windows_per_frame", win_cnt, 8);
      check_val("first_valid_pixel", first_at, 37);
      check_val("first_pic3", first_pic[3], 3);
      check_val("first_pic4", first_pic[4], 0);
    end

    stream_frame(1, 1'b0);
    check_val("gapped_windows", win_cnt, 8);
    check_val("gapped_first_pixel", first_at, 37);

    stream_frame(2, 1'b1);
    check_val("ready_after_reload", bus.weight_ready, 1'b1);
    stream_frame(2, 1'b0);
    check_val("random_windows", win_cnt, 8);

    // asynchronous reset mid-frame at pixel 20
    for (int i = 0; i < 20; i++) step(1'b1, PB'($urandom), 1'b0, '0);
    #3;
    rst_n = 1'b0;
    bus.pix_valid = 1'b0; bus.w_load_valid = 1'b0;
    #1 check_zero_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_weights(1'b0);
    stream_frame(0, 1'b0);
    check_val("post_reset_windows", win_cnt, 8);
    check_val("post_reset_first_pixel", first_at, 37);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
